// File: rtl/param_sp_ram_if.sv
// rtl/param_sp_ram_if.sv - access bus for param_sp_ram: request, write data, byte enables, read response, busy.
interface param_sp_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;
    logic                  busy;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/param_sp_ram.sv
// rtl/param_sp_ram.sv - single-port byte-enable RAM with post-reset clear sweep; PARAM_SP_RAM_OUTREG_EN adds an output register stage.
module param_sp_ram #(
    parameter int              DATA_W   = 8,
    parameter int              ADDR_W   = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter bit              RD_ON_WR = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    param_sp_ram_if.slave   bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  cur_word;
    logic               acc;
    logic               rd_fire;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Writes merge byte lanes into the current word, so the old word is read before the edge.
    always_comb begin
        cur_word  = mem[bus.addr];
        acc       = (state_q == ST_READY) && bus.req;
        rd_fire   = acc && (!bus.we || RD_ON_WR);
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
        mem_wdata = cur_word;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = INIT_VAL;
        end else if (acc && bus.we) begin
            mem_we = 1'b1;
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.be[i]) begin
                    mem_wdata[8*i +: 8] = bus.wdata[8*i +: 8];
                end
            end
        end
        rdata_d  = rd_fire ? cur_word : rdata_q;
        rvalid_d = rd_fire;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.busy = (state_q == ST_CLEAR);

`ifdef PARAM_SP_RAM_OUTREG_EN
    logic [DATA_W-1:0]  rdata2_q, rdata2_d;
    logic               rvalid2_q, rvalid2_d;

    always_comb begin
        rvalid2_d = rvalid_q;
        rdata2_d  = rvalid_q ? rdata_q : rdata2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata2_q  <= '0;
            rvalid2_q <= 1'b0;
        end else begin
            rdata2_q  <= rdata2_d;
            rvalid2_q <= rvalid2_d;
        end
    end

    assign bus.rdata  = rdata2_q;
    assign bus.rvalid = rvalid2_q;
`else
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`endif
endmodule

// File: tb/tb_param_sp_ram.sv
// tb/tb_param_sp_ram.sv - self-checking bench for param_sp_ram: 8-bit write-only-silent and 32-bit read-first instances.
module tb_param_sp_ram;
`ifdef PARAM_SP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] INIT_B = 32'h5A5A_0F0F;

    typedef struct {
        bit          v;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          exp_v;
        logic [31:0] exp_d;
    } vec_t;

    logic clk;
    logic rst_n;

    param_sp_ram_if #(.DATA_W(8),  .ADDR_W(6)) bus_a ();
    param_sp_ram_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

    param_sp_ram #(.DATA_W(8), .ADDR_W(6), .INIT_VAL(8'h00), .RD_ON_WR(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    param_sp_ram #(.DATA_W(32), .ADDR_W(4), .INIT_VAL(INIT_B), .RD_ON_WR(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem_a [64];
    logic [31:0] mem_b [16];
    int          sweep_a, sweep_b;
    logic [31:0] exp_rd_a, exp_rd_b;
    exp_t        pipe_a [$];
    exp_t        pipe_b [$];
    vec_t        tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_t idle;
        idle.v = 1'b0;
        idle.d = '0;
        for (int i = 0; i < 64; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem_b[i] = INIT_B;
        sweep_a  = 64;
        sweep_b  = 16;
        exp_rd_a = '0;
        exp_rd_b = '0;
        pipe_a.delete();
        pipe_b.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            pipe_a.push_back(idle);
            pipe_b.push_back(idle);
        end
    endtask

    // One clock: inputs already driven, model predicts, outputs compared at the following negedge.
    task automatic tick();
        exp_t ea, eb, oa, ob;
        chk("busy_a", 32'(bus_a.busy), 32'(sweep_a > 0));
        chk("busy_b", 32'(bus_b.busy), 32'(sweep_b > 0));
        ea.v = 1'b0; ea.d = '0;
        eb.v = 1'b0; eb.d = '0;
        if (sweep_a > 0) begin
            sweep_a--;
        end else if (bus_a.req) begin
            if (!bus_a.we) begin
                ea.v = 1'b1;
                ea.d = 32'(mem_a[bus_a.addr]);
            end else if (bus_a.be[0]) begin
                mem_a[bus_a.addr] = bus_a.wdata;
            end
        end
        if (sweep_b > 0) begin
            sweep_b--;
        end else if (bus_b.req) begin
            eb.v = 1'b1;
            eb.d = mem_b[bus_b.addr];
            if (bus_b.we) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus_b.be[i]) mem_b[bus_b.addr][8*i +: 8] = bus_b.wdata[8*i +: 8];
                end
            end
        end
        pipe_a.push_back(ea);
        pipe_b.push_back(eb);
        @(negedge clk);
        oa = pipe_a.pop_front();
        ob = pipe_b.pop_front();
        if (oa.v) exp_rd_a = oa.d;
        if (ob.v) exp_rd_b = ob.d;
        chk("rvalid_a", 32'(bus_a.rvalid), 32'(oa.v));
        chk("rdata_a",  32'(bus_a.rdata),  exp_rd_a);
        chk("rvalid_b", 32'(bus_b.rvalid), 32'(ob.v));
        chk("rdata_b",  bus_b.rdata,       exp_rd_b);
    endtask

    task automatic idle_inputs();
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0; bus_a.be = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0; bus_b.be = '0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rdata_a",  32'(bus_a.rdata),  32'h0);
        chk("rst_rvalid_a", 32'(bus_a.rvalid), 32'h0);
        chk("rst_busy_a",   32'(bus_a.busy),   32'h1);
        chk("rst_rdata_b",  bus_b.rdata,       32'h0);
        chk("rst_rvalid_b", 32'(bus_b.rvalid), 32'h0);
        chk("rst_busy_b",   32'(bus_b.busy),   32'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sweep_and_count();
        int cnt_a = 0;
        int cnt_b = 0;
        int n = 0;
        while ((bus_a.busy || bus_b.busy) && n < 200) begin
            if (bus_a.busy) cnt_a++;
            if (bus_b.busy) cnt_b++;
            n++;
            tick();
        end
        chk("busy_cycles_a", 32'(cnt_a), 32'd64);
        chk("busy_cycles_b", 32'(cnt_b), 32'd16);
    endtask

    task automatic read_all();
        int rv = 0;
        idle_inputs();
        for (int i = 0; i < 64; i++) begin
            bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 6'(i);
            bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.addr = 4'(i);
            tick();
            if (bus_a.rvalid) rv++;
        end
        idle_inputs();
        for (int i = 0; i < LAT; i++) begin
            tick();
            if (bus_a.rvalid) rv++;
        end
        chk("read_all_rvalid_count_a", 32'(rv), 32'd64);
    endtask

    initial begin
        int          rv_idx [3];
        logic [31:0] rv_dat [3];
        int          k;

        tbl[0] = '{1'b1, 4'd5,  32'hAABB_CCDD, 4'b1111, 1'b1, INIT_B};
        tbl[1] = '{1'b1, 4'd5,  32'h1122_3344, 4'b0101, 1'b1, 32'hAABB_CCDD};
        tbl[2] = '{1'b0, 4'd5,  32'h0,         4'b0000, 1'b1, 32'hAA22_CC44};
        tbl[3] = '{1'b1, 4'd3,  32'h0000_0055, 4'b1111, 1'b1, INIT_B};
        tbl[4] = '{1'b1, 4'd3,  32'h0000_0099, 4'b0001, 1'b1, 32'h0000_0055};
        tbl[5] = '{1'b0, 4'd3,  32'h0,         4'b0000, 1'b1, 32'h0000_0099};
        tbl[6] = '{1'b1, 4'd5,  32'hFFFF_FFFF, 4'b0000, 1'b1, 32'hAA22_CC44};
        tbl[7] = '{1'b0, 4'd5,  32'h0,         4'b0000, 1'b1, 32'hAA22_CC44};
        tbl[8] = '{1'b1, 4'd15, 32'hDEAD_BEEF, 4'b1111, 1'b1, INIT_B};
        tbl[9] = '{1'b0, 4'd15, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEEF};

        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("por_rdata_a",  32'(bus_a.rdata),  32'h0);
        chk("por_rvalid_a", 32'(bus_a.rvalid), 32'h0);
        chk("por_busy_a",   32'(bus_a.busy),   32'h1);
        chk("por_rdata_b",  bus_b.rdata,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Writes during the sweep must be dropped.
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 6'd0; bus_a.wdata = 8'hFF; bus_a.be = 1'b1;
        sweep_and_count();
        idle_inputs();
        read_all();

        for (int t = 0; t < 10; t++) begin
            idle_inputs();
            bus_b.req = 1'b1; bus_b.we = tbl[t].we; bus_b.addr = tbl[t].addr;
            bus_b.wdata = tbl[t].wdata; bus_b.be = tbl[t].be;
            tick();
            idle_inputs();
            for (int i = 0; i < LAT - 1; i++) tick();
            chk($sformatf("tbl%0d_rvalid_b", t), 32'(bus_b.rvalid), 32'(tbl[t].exp_v));
            chk($sformatf("tbl%0d_rdata_b", t),  bus_b.rdata,       tbl[t].exp_d);
        end

        // Read immediately after a write to the same address, including the top address.
        idle_inputs();
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 6'd7;  bus_a.wdata = 8'h3C; bus_a.be = 1'b1;
        tick();
        chk("wr_no_rvalid_a", 32'(bus_a.rvalid), 32'h0);
        bus_a.we = 1'b0;
        tick();
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 6'd63; bus_a.wdata = 8'hC3;
        for (int i = 0; i < LAT - 1; i++) tick();
        chk("raw_rdata_a", 32'(bus_a.rdata), 32'h3C);
        if (LAT == 2) bus_a.we = 1'b0;
        tick();
        bus_a.we = 1'b0;
        tick();
        idle_inputs();
        for (int i = 0; i < LAT - 1; i++) tick();
        chk("wrap_rdata_a", 32'(bus_a.rdata), 32'hC3);

        // Back-to-back reads: each response exactly LAT cycles after its request, in order.
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 6'(i); bus_a.wdata = 8'(i * 17); bus_a.be = 1'b1;
            tick();
        end
        k = 0;
        for (int i = 0; i < 3; i++) begin
            rv_idx[i] = -1;
            rv_dat[i] = '0;
        end
        for (int c = 0; c < 3 + LAT + 1; c++) begin
            if (c < 3) begin
                bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 6'(c + 1);
            end else begin
                bus_a.req = 1'b0;
            end
            tick();
            if (bus_a.rvalid && k < 3) begin
                rv_idx[k] = c;
                rv_dat[k] = 32'(bus_a.rdata);
                k++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b%0d_cycle", i), 32'(rv_idx[i]), 32'(LAT - 1 + i));
            chk($sformatf("b2b%0d_data", i),  rv_dat[i],      32'((i + 1) * 17));
        end

        for (int c = 0; c < 500; c++) begin
            bus_a.req = 1'($urandom); bus_a.we = 1'($urandom); bus_a.addr = 6'($urandom);
            bus_a.wdata = 8'($urandom); bus_a.be = 1'($urandom);
            bus_b.req = 1'($urandom); bus_b.we = 1'($urandom); bus_b.addr = 4'($urandom);
            bus_b.wdata = $urandom; bus_b.be = 4'($urandom);
            tick();
        end

        // Reset mid-access, then again partway through the sweep.
        bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 6'd1;
        bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.addr = 4'd5;
        tick();
        do_reset();
        idle_inputs();
        for (int i = 0; i < 20; i++) tick();
        do_reset();
        sweep_and_count();
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/param_sp_ram.md
PARAM_SP_RAM -- requirements
Module: param_sp_ram

Interface
REQ-001 Parameter DATA_W, default 8: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 6: address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter INIT_VAL, default 0: DATA_W-bit value written to every word by the clear sweep.
REQ-004 Parameter RD_ON_WR, default 0: 0 = write leaves rdata/rvalid untouched; 1 = write returns the old word (read-first).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  1  access request, sampled on the rising edge of clk.
REQ-008 we  input  1  1 = write, 0 = read; qualified by req.
REQ-009 addr  input  ADDR_W  word address.
REQ-010 wdata  input  DATA_W  write data.
REQ-011 be  input  DATA_W/8  byte enables for writes; bit i covers wdata[8i+7:8i].
REQ-012 rdata  output  DATA_W  registered read data.
REQ-013 rvalid  output  1  one-cycle pulse marking rdata as valid.
REQ-014 busy  output  1  high while the clear sweep runs.

Function
REQ-015 FSM states: CLEAR and READY; reset enters CLEAR with sweep pointer = 0.
REQ-016 CLEAR: each cycle write INIT_VAL to all bytes of word[ptr]; after ptr = DEPTH-1, go to READY with the pointer wrapping to 0; the sweep takes exactly DEPTH cycles.
REQ-017 busy = 1 in CLEAR and 0 in READY; req is ignored (no write, no rvalid) while busy = 1.
REQ-018 READY, req=1 and we=1: update only the bytes with be[i]=1; be=0 is a legal no-op access.
REQ-019 READY, req=1 and we=0: rdata = word[addr] with rvalid=1 on the next edge; latency 1 cycle, back-to-back reads at one per cycle.
REQ-020 RD_ON_WR=1: a write also loads rdata with the pre-write word and pulses rvalid; RD_ON_WR=0: rvalid stays 0 for writes.
REQ-021 rdata holds its last value when no read completes; rvalid is 0 in every cycle without a completed access.
REQ-022 A read the cycle after a write to the same address returns the newly written bytes.
REQ-023 Address wrap: no bounds check; every ADDR_W value addresses a valid word.
REQ-024 req is level-sensitive; each cycle with req=1 in READY is one independent access.

Reset
REQ-025 On rst_n=0, immediately: rdata = 0, rvalid = 0, busy = 1, state = CLEAR, ptr = 0.
REQ-026 Reset asserted mid-sweep or mid-access aborts it; the full sweep restarts from word 0 after release.
REQ-027 Memory contents are not reset directly; only the sweep defines them.

Configuration
REQ-028 Macro PARAM_SP_RAM_OUTREG_EN defined: an extra output register stage is added; read latency is 2 cycles and rvalid is delayed to match; throughput is unchanged.
REQ-029 Macro undefined: read latency is 1 cycle per REQ-019; reset values are identical in both builds.

Verification
REQ-030 Release reset, DATA_W=8, ADDR_W=6: busy=1 for exactly 64 cycles; then read all 64 addresses -> rdata=INIT_VAL (0x00) each, rvalid one cycle after each req.
REQ-031 DATA_W=32: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read addr 5 returns 0xAA22CC44.
REQ-032 RD_ON_WR=1: addr 3 holds 0x55; write 0x99 -> rdata=0x55 with rvalid=1; next read of addr 3 -> 0x99.
REQ-033 Assert rst_n=0 at sweep word 20 after writing data -> rdata=0 and rvalid=0 immediately; after release busy lasts 64 cycles and all words read INIT_VAL.
REQ-034 req=1 during busy with we=1, addr 0, data 0xFF -> ignored, rvalid stays 0; after the sweep, addr 0 reads INIT_VAL.
REQ-035 With PARAM_SP_RAM_OUTREG_EN, issue back-to-back reads of addr 1,2,3 -> rvalid for each 2 cycles after its req, in order, with the correct data.
